// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle add/sub/logic, bit-serial shifts and a shift-add multiplier.
// result/zero_out/carry_out are registered and only change on the edge entering FIN.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero_out,
  output logic             carry_out
);

  localparam int CW = SHW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;

  logic             accept_s;
  logic             load_s;
  logic [WIDTH-1:0] new_res_s;
  logic             new_cy_s;
  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   sub_s;
  logic [WIDTH:0]   sum_s;
  logic [SHW-1:0]   amt_s;
  logic             last_s;

  assign add_s  = {1'b0, a} + {1'b0, b};
  assign sub_s  = {1'b0, a} - {1'b0, b};
  assign amt_s  = b[SHW-1:0];
  assign last_s = (cnt_q == CW'(1));
  // One shift-add step: {acc_q, b_q} holds the running product, multiplier bits consumed from b_q[0].
  assign sum_s  = {1'b0, acc_q} + ({(WIDTH+1){b_q[0]}} & {1'b0, a_q});
  assign accept_s = start && (state_q != S_RUN);

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_FIN);
  assign result    = res_q;
  assign zero_out  = zero_q;
  assign carry_out = carry_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    load_s    = 1'b0;
    new_res_s = '0;
    new_cy_s  = 1'b0;

    case (state_q)
      S_IDLE, S_FIN: begin
        if (accept_s) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_FIN;
          case (op)
            OP_ADD: begin load_s = 1'b1; new_res_s = add_s[WIDTH-1:0]; new_cy_s = add_s[WIDTH]; end
            OP_SUB: begin load_s = 1'b1; new_res_s = sub_s[WIDTH-1:0]; new_cy_s = sub_s[WIDTH]; end
            OP_AND: begin load_s = 1'b1; new_res_s = a & b; end
            OP_OR:  begin load_s = 1'b1; new_res_s = a | b; end
            OP_XOR: begin load_s = 1'b1; new_res_s = a ^ b; end
            OP_SHL, OP_SHR: begin
              if (amt_s == '0) begin
                load_s    = 1'b1;
                new_res_s = a;
              end else begin
                cnt_d   = {1'b0, amt_s};
                state_d = S_RUN;
              end
            end
            OP_MUL: begin
              cnt_d   = CW'(WIDTH);
              state_d = S_RUN;
            end
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        case (op_q)
          OP_SHL: begin
            a_d = {a_q[WIDTH-2:0], 1'b0};
            if (last_s) begin
              load_s    = 1'b1;
              new_res_s = {a_q[WIDTH-2:0], 1'b0};
              new_cy_s  = a_q[WIDTH-1];
              state_d   = S_FIN;
            end else begin
              state_d = S_RUN;
            end
          end
          OP_SHR: begin
            a_d = {1'b0, a_q[WIDTH-1:1]};
            if (last_s) begin
              load_s    = 1'b1;
              new_res_s = {1'b0, a_q[WIDTH-1:1]};
              new_cy_s  = a_q[0];
              state_d   = S_FIN;
            end else begin
              state_d = S_RUN;
            end
          end
          OP_MUL: begin
            acc_d = sum_s[WIDTH:1];
            b_d   = {sum_s[0], b_q[WIDTH-1:1]};
            if (last_s) begin
              load_s    = 1'b1;
              new_res_s = {sum_s[0], b_q[WIDTH-1:1]};
              new_cy_s  = |sum_s[WIDTH:1];
              state_d   = S_FIN;
            end else begin
              state_d = S_RUN;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
      default: state_d = S_IDLE;
    endcase

    if (load_s) begin
      res_d   = new_res_s;
      zero_d  = (new_res_s == '0);
      carry_d = new_cy_s;
    end else begin
      res_d   = res_q;
      zero_d  = zero_q;
      carry_d = carry_q;
    end
  end

  // State, operand and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= S_IDLE;
      op_q    <= 3'b000;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes expected results with their done cycle,
// a negedge monitor pops and compares whenever done is seen.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clear_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] result;
  logic         zero_out, carry_out;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .clear_n(clear_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero_out(zero_out), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         c;
    int           when;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_fail = 0;
  logic [W-1:0] last_res = '0;
  logic         last_z = 1'b0;
  logic         last_c = 1'b0;
  int           busy_lo = 1, busy_hi = 0;
  int           issue_cyc = 0, next_free = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain unsigned arithmetic on ints.
  function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic c, output int lat);
    int xi, yi, amt, full;
    xi = x; yi = y; amt = yi % W; lat = 1; c = 1'b0; r = '0;
    case (o)
      3'd0: begin full = xi + yi; r = W'(full); c = (full >= (1 << W)); end
      3'd1: begin r = W'(xi - yi); c = (xi < yi); end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: begin
        r = W'(xi << amt);
        c = (amt != 0) && (((xi >> (W - amt)) & 1) != 0);
        lat = (amt == 0) ? 1 : amt + 1;
      end
      3'd6: begin
        r = W'(xi >> amt);
        c = (amt != 0) && (((xi >> (amt - 1)) & 1) != 0);
        lat = (amt == 0) ? 1 : amt + 1;
      end
      default: begin full = xi * yi; r = W'(full); c = ((full >> W) != 0); lat = W + 1; end
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    logic         c;
    int           lat;
    model(o, x, y, r, c, lat);
    op = o; a = x; b = y; start = 1'b1;
    sb.push_back('{res: r, z: (r == '0), c: c, when: cyc + lat});
    issue_cyc = cyc;
    busy_lo   = cyc + 1;
    busy_hi   = cyc + lat - 1;
    next_free = cyc + lat;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: quiet, 1: random ignored starts, 2: ignored starts at relative cycles 2 and 5
  task automatic wait_free(input int mode);
    int rel;
    while (cyc < next_free) begin
      rel   = cyc - issue_cyc;
      start = 1'b0;
      if ((mode == 1 && $urandom_range(1) == 1) || (mode == 2 && (rel == 2 || rel == 5))) begin
        start = 1'b1;
        op    = 3'($urandom);
        a     = W'($urandom);
        b     = W'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      start = 1'b0;
      @(negedge clk);
    end
  endtask

  exp_t e;
  always @(negedge clk) begin
    if (clear_n) begin
      check("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.when);
          check("result", 32'(result), 32'(e.res));
          check("zero_out", 32'(zero_out), 32'(e.z));
          check("carry_out", 32'(carry_out), 32'(e.c));
          last_res = e.res; last_z = e.z; last_c = e.c;
        end
      end else begin
        check("outputs_held", 32'({result, zero_out, carry_out}), 32'({last_res, last_z, last_c}));
        if (sb.size() > 0 && sb[0].when < cyc) begin
          check("missed_done", 32'd0, 32'd1);
          e = sb.pop_front();
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]   ro;
    logic [W-1:0] rx, ry;
    clear_n = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_state", 32'({busy, done, result, zero_out, carry_out}), 32'd0);
    clear_n = 1'b1;
    @(negedge clk);

    issue(3'd0, 8'hFF, 8'h01); wait_free(0);
    issue(3'd1, 8'h05, 8'h07); wait_free(0); idle(1);
    issue(3'd5, 8'h81, 8'h03); wait_free(0);
    issue(3'd6, 8'h81, 8'h01); wait_free(0);
    issue(3'd6, 8'h81, 8'h08); wait_free(0); idle(1);
    issue(3'd7, 8'h10, 8'h10); wait_free(2);
    issue(3'd7, 8'h0C, 8'h0B); wait_free(0); idle(2);

    // Asynchronous reset four cycles into a multiply.
    issue(3'd7, 8'h55, 8'hAA);
    idle(3);
    #2 clear_n = 1'b0;
    #1 check("async_reset", 32'({busy, done, result, zero_out, carry_out}), 32'd0);
    sb.delete();
    busy_lo = 1; busy_hi = 0;
    last_res = '0; last_z = 1'b0; last_c = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clear_n = 1'b1;
    next_free = cyc;
    idle(12);
    issue(3'd0, 8'h03, 8'h04); wait_free(0); idle(1);

    issue(3'd2, 8'hF0, 8'h0F);
    issue(3'd3, 8'hF0, 8'h0F); wait_free(0); idle(1);

    repeat (300) begin
      ro = 3'($urandom_range(7));
      rx = W'($urandom);
      ry = ($urandom_range(3) == 0) ? W'($urandom_range(W - 1)) : W'($urandom);
      issue(ro, rx, ry);
      wait_free(1);
      if ($urandom_range(2) == 0) idle($urandom_range(2));
    end

    idle(4);
    check("queue_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
